// File: rtl/grf_mp_sb.sv
// Multi-port general register file with two write ports, optional write-to-read bypass and a
// per-register busy scoreboard. Define GRF_TRACE_EN to print one line per committed write.
module grf_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic [31:0]                wpc0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [31:0]                wpc1,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  // Writes and issues are single-cycle strobes with no back-pressure: a write or issue
  // presented with its enable high is always accepted at the next posedge.

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              w0_act;
  logic              w1_act;
  logic              iss_act;

  // Register 0 is hard-wired when ZERO_REG is set, so writes and issues to it are dropped.
  assign w0_act  = we0       && !((ZERO_REG != 0) && (waddr0   == '0));
  assign w1_act  = we1       && !((ZERO_REG != 0) && (waddr1   == '0));
  assign iss_act = iss_valid && !((ZERO_REG != 0) && (iss_addr == '0));

  // Clears from writes first, then the issue set, so set wins on the same register.
  always_comb begin
    busy_nxt = busy;
    if (w0_act) busy_nxt[waddr0] = 1'b0;
    if (w1_act) busy_nxt[waddr1] = 1'b0;
    if (iss_act) busy_nxt[iss_addr] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        regs[k] <= '0;
      end
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      if (w0_act) regs[waddr0] <= wdata0;
      if (w1_act) regs[waddr1] <= wdata1;
    end
  end

  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd;
  logic              rb;

  // W1 is the younger write, so it takes priority over W0 on the bypass path.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    rd    = '0;
    rb    = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = raddr[i*ADDR_W +: ADDR_W];
      rd = regs[ra];
      rb = busy[ra];
      if (BYPASS != 0) begin
        if (w1_act && (waddr1 == ra)) begin
          rd = wdata1;
          rb = 1'b0;
        end else if (w0_act && (waddr0 == ra)) begin
          rd = wdata0;
          rb = 1'b0;
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
        rb = 1'b0;
      end
      rdata[i*DATA_W +: DATA_W] = rd;
      rbusy[i] = rb;
    end
  end

`ifdef GRF_TRACE_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (w0_act) $display("%d@%h: $%d <= %h", $time, wpc0, waddr0, wdata0);
      if (w1_act) $display("%d@%h: $%d <= %h", $time, wpc1, waddr1, wdata1);
    end
  end
`else
  logic [63:0] unused_wpc;
  assign unused_wpc = {wpc0, wpc1};
`endif

endmodule

// File: tb/tb_grf_mp_sb.sv
// Bench for grf_mp_sb (default parameters): directed vector table, then random traffic
// checked against an array-based model of the register file and scoreboard.
module tb_grf_mp_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        we0, we1, iss_valid;
  logic [4:0]  waddr0, waddr1, iss_addr;
  logic [31:0] wdata0, wdata1, wpc0, wpc1;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [5:0]  busy_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  grf_mp_sb dut (
    .clk(clk), .reset(reset),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .wpc0(wpc0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .wpc1(wpc1),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
  );

  typedef struct {
    logic rst;
    logic we0; logic [4:0] wa0; logic [31:0] wd0;
    logic we1; logic [4:0] wa1; logic [31:0] wd1;
    logic iv;  logic [4:0] ia;
    logic [4:0] ra0; logic [4:0] ra1;
    logic [31:0] e0; logic [31:0] e1; logic [1:0] eb; logic [5:0] ec;
  } vec_t;

  vec_t tbl[$];

  // model state
  logic [31:0] m_reg [32];
  logic        m_busy[32];
  logic [5:0]  exp_q[$];

  function automatic vec_t mk(logic rst, logic w0, logic [4:0] a0, logic [31:0] d0,
                              logic w1, logic [4:0] a1, logic [31:0] d1,
                              logic iv, logic [4:0] ia, logic [4:0] r0, logic [4:0] r1,
                              logic [31:0] e0, logic [31:0] e1, logic [1:0] eb, logic [5:0] ec);
    vec_t v;
    v.rst = rst; v.we0 = w0; v.wa0 = a0; v.wd0 = d0; v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
    v.iv = iv; v.ia = ia; v.ra0 = r0; v.ra1 = r1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst;
    we0 = v.we0; waddr0 = v.wa0; wdata0 = v.wd0;
    we1 = v.we1; waddr1 = v.wa1; wdata1 = v.wd1;
    iss_valid = v.iv; iss_addr = v.ia;
    raddr = {v.ra1, v.ra0};
    wpc0 = 32'h1000; wpc1 = 32'h2000;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] exp_rd(logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we1 && waddr1 == a) return wdata1;
    if (we0 && waddr0 == a) return wdata0;
    return m_reg[a];
  endfunction

  function automatic logic exp_rb(logic [4:0] a);
    if (a == 0) return 1'b0;
    if ((we1 && waddr1 == a) || (we0 && waddr0 == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_step();
    int n;
    if (reset) begin
      for (int k = 0; k < 32; k++) begin
        m_reg[k] = 32'h0;
        m_busy[k] = 1'b0;
      end
    end else begin
      if (we0 && waddr0 != 0) begin m_reg[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
      if (we1 && waddr1 != 0) begin m_reg[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
      if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
    n = 0;
    for (int k = 0; k < 32; k++) n += int'(m_busy[k]);
    exp_q.push_back(6'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle;
    idle = mk(0, 0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0);
    drive(idle);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state on every address
    for (int a = 0; a < 32; a += 2) begin
      raddr = {5'(a + 1), 5'(a)};
      #1;
      chk("rst_rdata", a, rdata, 64'h0);
      chk("rst_rbusy", a, {62'h0, rbusy}, 64'h0);
      chk("rst_cnt", a, {58'h0, busy_cnt}, 64'h0);
    end

    tbl.push_back(mk(0, 0,0,0,            0,0,0,             0,0, 0,31, 0,0, 2'b00, 0));
    tbl.push_back(mk(0, 0,0,0,            1,5,32'hDEADBEEF,  0,0, 5,5,  32'hDEADBEEF,32'hDEADBEEF, 2'b00, 0));
    tbl.push_back(mk(0, 0,0,0,            0,0,0,             0,0, 5,6,  32'hDEADBEEF,0, 2'b00, 0));
    tbl.push_back(mk(0, 1,7,1,            1,7,2,             0,0, 7,7,  2,2, 2'b00, 0));
    tbl.push_back(mk(0, 0,0,0,            0,0,0,             0,0, 7,5,  2,32'hDEADBEEF, 2'b00, 0));
    tbl.push_back(mk(0, 0,0,0,            0,0,0,             1,3, 3,4,  0,0, 2'b00, 0));
    tbl.push_back(mk(0, 0,0,0,            0,0,0,             1,4, 3,4,  0,0, 2'b01, 1));
    tbl.push_back(mk(0, 0,0,0,            0,0,0,             0,0, 3,4,  0,0, 2'b11, 2));
    tbl.push_back(mk(0, 1,3,32'h33,       0,0,0,             0,0, 3,4,  32'h33,0, 2'b10, 2));
    tbl.push_back(mk(0, 0,0,0,            1,4,32'h44,        1,4, 3,4,  32'h33,32'h44, 2'b00, 1));
    tbl.push_back(mk(0, 0,0,0,            0,0,0,             0,0, 3,4,  32'h33,32'h44, 2'b10, 1));
    tbl.push_back(mk(0, 1,0,32'hFFFFFFFF, 0,0,0,             1,0, 0,0,  0,0, 2'b00, 1));
    tbl.push_back(mk(0, 0,0,0,            0,0,0,             0,0, 0,4,  0,32'h44, 2'b10, 1));
    tbl.push_back(mk(0, 1,4,32'h45,       0,0,0,             1,1, 1,4,  0,32'h45, 2'b00, 1));
    tbl.push_back(mk(0, 0,0,0,            0,0,0,             1,2, 1,2,  0,0, 2'b01, 1));
    tbl.push_back(mk(0, 0,0,0,            0,0,0,             1,3, 2,3,  0,32'h33, 2'b01, 2));
    tbl.push_back(mk(1, 1,9,32'h99,       1,10,32'hAA,       1,5, 3,1,  32'h33,0, 2'b11, 3));
    tbl.push_back(mk(0, 0,0,0,            0,0,0,             0,0, 3,5,  0,0, 2'b00, 0));
    tbl.push_back(mk(0, 0,0,0,            0,0,0,             0,0, 9,10, 0,0, 2'b00, 0));
    tbl.push_back(mk(0, 0,0,0,            0,0,0,             0,0, 7,4,  0,0, 2'b00, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk("vec_rdata0", i, {32'h0, rdata[31:0]},  {32'h0, tbl[i].e0});
      chk("vec_rdata1", i, {32'h0, rdata[63:32]}, {32'h0, tbl[i].e1});
      chk("vec_rbusy",  i, {62'h0, rbusy},        {62'h0, tbl[i].eb});
      chk("vec_cnt",    i, {58'h0, busy_cnt},     {58'h0, tbl[i].ec});
    end

    // random traffic against the model; first cycle forces reset to sync the model
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      reset     = (c == 0) || ($urandom_range(0, 49) == 0);
      we0       = 1'($urandom_range(0, 1));
      waddr0    = rnd_addr();
      wdata0    = $urandom;
      we1       = 1'($urandom_range(0, 1));
      waddr1    = ($urandom_range(0, 3) == 0) ? waddr0 : rnd_addr();
      wdata1    = $urandom;
      iss_valid = ($urandom_range(0, 2) != 0);
      iss_addr  = ($urandom_range(0, 5) == 0) ? waddr1 : rnd_addr();
      raddr     = {rnd_addr(), rnd_addr()};
      #1;
      if (!reset) begin
        chk("rnd_rdata0", c, {32'h0, rdata[31:0]},  {32'h0, exp_rd(raddr[4:0])});
        chk("rnd_rdata1", c, {32'h0, rdata[63:32]}, {32'h0, exp_rd(raddr[9:5])});
        chk("rnd_rbusy",  c, {62'h0, rbusy}, {62'h0, exp_rb(raddr[9:5]), exp_rb(raddr[4:0])});
      end
      if (exp_q.size() > 0) chk("rnd_cnt", c, {58'h0, busy_cnt}, {58'h0, exp_q.pop_front()});
      model_step();
    end

    @(negedge clk);
    drive(idle);
    #1;
    if (exp_q.size() > 0) chk("rnd_cnt_last", 0, {58'h0, busy_cnt}, {58'h0, exp_q.pop_front()});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
